// File: rtl/shared_dmem_arbiter_pkg.sv
// shared_dmem_arbiter_pkg: FSM state encoding and core index constants
package shared_dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;
  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;
endpackage

// File: rtl/shared_dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick
// Ports: Req0/Req1 requests, last = index granted most recently,
//        grant_valid = some request present, grant_idx = winning core.
module rr_pick2
  import shared_dmem_arbiter_pkg::*;
(
  input  logic Req0,
  input  logic Req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);
  assign grant_valid = Req0 | Req1;
  // on a tie the core that did not win last time goes next
  assign grant_idx   = (Req0 & Req1) ? ~last : (Req1 ? CORE1 : CORE0);
endmodule

// File: rtl/shared_dmem_arbiter.sv
// shared_dmem_arbiter: round-robin arbiter sharing one data memory port between two cores
// Ports: Clk, Reset (async active-low); per core ReqN/WrN/AddrN/WDataN in, AckN/StallN out;
//        RData/Err completion result; MemReq/MemWe/MemAddr/MemWData registered memory
//        request, MemRData/MemReady memory response.
module shared_dmem_arbiter
  import shared_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Wr0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  input  logic              Req1,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] RData,
  output logic              Err,
  output logic              Stall0,
  output logic              Stall1,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemReady
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  state_t          state, state_nx;
  logic            owner, last, grant_valid, grant_idx, timed_out;
  logic [CW-1:0]   cnt;
  rr_pick2 u_pick (
    .Req0       (Req0),
    .Req1       (Req1),
    .last       (last),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );
  assign timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  always_comb begin
    state_nx = (state == IDLE) ? (grant_valid ? BUSY : IDLE) :
               (state == BUSY) ? ((MemReady || timed_out) ? RESP : BUSY) : IDLE;
  end
  assign Ack0   = (state == RESP) && (owner == CORE0);
  assign Ack1   = (state == RESP) && (owner == CORE1);
  assign Stall0 = Req0 & ~Ack0;
  assign Stall1 = Req1 & ~Ack1;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      owner    <= CORE0;
      last     <= CORE1;
      cnt      <= '0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      RData    <= '0;
      Err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant_valid) begin
        owner    <= grant_idx;
        last     <= grant_idx;
        cnt      <= '0;
        MemReq   <= 1'b1;
        MemWe    <= grant_idx ? Wr1 : Wr0;
        MemAddr  <= grant_idx ? Addr1 : Addr0;
        MemWData <= grant_idx ? WData1 : WData0;
      end
      if (state == BUSY) begin
        if (MemReady || timed_out) begin
          RData  <= (MemReady && !MemWe) ? MemRData : '0;
          Err    <= !MemReady;
          MemReq <= 1'b0;
          MemWe  <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (state == RESP) Err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// tb_shared_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_shared_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  logic          Clk = 1'b0, Reset = 1'b0;
  logic          Req0 = 1'b0, Wr0 = 1'b0, Req1 = 1'b0, Wr1 = 1'b0, MemReady = 1'b0;
  logic [AW-1:0] Addr0 = '0, Addr1 = '0;
  logic [DW-1:0] WData0 = '0, WData1 = '0, MemRData = '0;
  logic          Ack0, Ack1, Err, Stall0, Stall1, MemReq, MemWe;
  logic [DW-1:0] RData, MemWData;
  logic [AW-1:0] MemAddr;
  int            tests = 0, fails = 0;

  always #5 Clk = ~Clk;

  shared_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Wr0(Wr0), .Addr0(Addr0), .WData0(WData0),
    .Req1(Req1), .Wr1(Wr1), .Addr1(Addr1), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .RData(RData), .Err(Err),
    .Stall0(Stall0), .Stall1(Stall1),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady)
  );

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk); Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; #12;
    tests++; if ({MemReq, MemWe, Ack0, Ack1, Err} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got %b want 00000", {MemReq, MemWe, Ack0, Ack1, Err}); end
    tests++; if (MemAddr !== '0 || MemWData !== '0) begin fails++; $display("FAIL reset_fields got %h/%h want 0/0", MemAddr, MemWData); end
    tests++; if (RData !== '0) begin fails++; $display("FAIL reset_rdata got %h want 0", RData); end
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    tests++; if (MemReq !== 1'b0 || Stall0 !== 1'b0) begin fails++; $display("FAIL idle_noreq got memreq=%b stall0=%b want 0/0", MemReq, Stall0); end
  endtask

  task automatic test_single_load();
    do_reset();
    @(negedge Clk); Req0 = 1; Wr0 = 0; Addr0 = 32'h40; MemReady = 1; MemRData = 32'hDEADBEEF;
    #1; tests++; if (Stall0 !== 1'b1) begin fails++; $display("FAIL load_stall_pre got %b want 1", Stall0); end
    @(posedge Clk); #1;
    tests++; if ({MemReq, MemWe, Ack0, Stall0} !== 4'b1001 || MemAddr !== 32'h40) begin fails++; $display("FAIL load_busy got req/we/ack/stall=%b addr=%h want 1001 addr=40", {MemReq, MemWe, Ack0, Stall0}, MemAddr); end
    @(posedge Clk); #1;
    tests++; if ({MemReq, Ack0, Ack1, Err, Stall0} !== 5'b01000) begin fails++; $display("FAIL load_ack got req/ack0/ack1/err/stall=%b want 01000", {MemReq, Ack0, Ack1, Err, Stall0}); end
    tests++; if (RData !== 32'hDEADBEEF) begin fails++; $display("FAIL load_rdata got %h want deadbeef", RData); end
    @(negedge Clk); Req0 = 0;
    @(posedge Clk); #1;
    tests++; if ({Ack0, MemReq} !== 2'b00) begin fails++; $display("FAIL load_after got ack/req=%b want 00", {Ack0, MemReq}); end
  endtask

  task automatic test_simultaneous();
    int a0 = -1, a1 = -1, n = 0;
    logic [AW-1:0] seen [4];
    @(negedge Clk); Reset = 0; MemReady = 1;
    Req0 = 1; Wr0 = 0; Addr0 = 32'h10; Req1 = 1; Wr1 = 0; Addr1 = 32'h20;
    @(negedge Clk); Reset = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      if (Ack0 && a0 < 0) a0 = c;
      if (Ack1 && a1 < 0) a1 = c;
      if (MemReq && n < 4) begin seen[n] = MemAddr; n++; end
      @(negedge Clk);
      if (a0 >= 0) Req0 = 0;
      if (a1 >= 0) Req1 = 0;
    end
    tests++; if (a0 !== 1 || a1 !== 4) begin fails++; $display("FAIL simul_ack_cycles got %0d/%0d want 1/4", a0, a1); end
    tests++; if (n !== 2 || seen[0] !== 32'h10 || seen[1] !== 32'h20) begin fails++; $display("FAIL simul_order got n=%0d %h,%h want 2 10,20", n, seen[0], seen[1]); end
  endtask

  task automatic test_contention();
    int seq [$];
    int both = 0;
    do_reset();
    @(negedge Clk); Req0 = 1; Req1 = 1; MemReady = 1;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clk); #1;
      if (Ack0 && Ack1) both++;
      if (Ack0) seq.push_back(0);
      if (Ack1) seq.push_back(1);
    end
    tests++; if (both != 0) begin fails++; $display("FAIL contention_both got %0d want 0", both); end
    tests++; if (seq.size() != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin fails++; $display("FAIL contention_seq got %p want 0,1,0,1", seq); end
    @(negedge Clk); Req0 = 0; Req1 = 0;
  endtask

  task automatic test_wait_states();
    int bad = 0;
    do_reset();
    @(negedge Clk); Req1 = 1; Wr1 = 1; Addr1 = 32'h8; WData1 = 32'h1234; MemReady = 0; MemRData = 32'hFFFF;
    for (int c = 0; c < 6; c++) begin
      @(posedge Clk); #1;
      if ({MemReq, MemWe, Ack1} !== 3'b110 || MemAddr !== 32'h8 || MemWData !== 32'h1234) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL wait_hold got %0d bad cycles want 0", bad); end
    @(negedge Clk); MemReady = 1;
    @(posedge Clk); #1;
    tests++; if ({Ack1, Ack0, Err, MemReq} !== 4'b1000 || RData !== '0) begin fails++; $display("FAIL wait_ack got ack1/ack0/err/req=%b rdata=%h want 1000 0", {Ack1, Ack0, Err, MemReq}, RData); end
    @(negedge Clk); Req1 = 0; Wr1 = 0;
  endtask

  task automatic test_timeout();
    int hi = 0;
    do_reset();
    @(negedge Clk); Req0 = 1; Wr0 = 0; Addr0 = 32'h44; MemReady = 0;
    @(posedge Clk); #1;
    while (MemReq === 1'b1 && hi < 40) begin hi++; @(posedge Clk); #1; end
    tests++; if (hi != TO) begin fails++; $display("FAIL timeout_len got %0d want %0d", hi, TO); end
    tests++; if ({Ack0, Err} !== 2'b11 || RData !== '0) begin fails++; $display("FAIL timeout_ack got ack/err=%b rdata=%h want 11 0", {Ack0, Err}, RData); end
    @(negedge Clk); Req0 = 0; Req1 = 1; Wr1 = 0; Addr1 = 32'h30; MemReady = 1; MemRData = 32'h55;
    @(posedge Clk); #1;
    tests++; if ({MemReq, Err, Ack0} !== 3'b000) begin fails++; $display("FAIL timeout_clear got req/err/ack=%b want 000", {MemReq, Err, Ack0}); end
    @(posedge Clk); #1;
    tests++; if (MemReq !== 1'b1 || MemAddr !== 32'h30) begin fails++; $display("FAIL timeout_next_grant got req=%b addr=%h want 1 30", MemReq, MemAddr); end
    @(posedge Clk); #1;
    tests++; if ({Ack1, Err} !== 2'b10 || RData !== 32'h55) begin fails++; $display("FAIL timeout_next_ack got ack/err=%b rdata=%h want 10 55", {Ack1, Err}, RData); end
    @(negedge Clk); Req1 = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge Clk); Req0 = 1; Wr0 = 0; Addr0 = 32'h100; MemReady = 0;
    @(posedge Clk); @(posedge Clk); #3; Reset = 0; #1;
    tests++; if ({MemReq, Ack0, Ack1} !== 3'b000) begin fails++; $display("FAIL midreset_drop got req/ack0/ack1=%b want 000", {MemReq, Ack0, Ack1}); end
    @(posedge Clk); #1;
    tests++; if ({MemReq, Ack0, Ack1} !== 3'b000) begin fails++; $display("FAIL midreset_hold got %b want 000", {MemReq, Ack0, Ack1}); end
    @(negedge Clk); Req0 = 0; Req1 = 1; Addr1 = 32'h200;
    @(negedge Clk); Reset = 1;
    @(posedge Clk); #1;
    tests++; if (MemReq !== 1'b1 || MemAddr !== 32'h200) begin fails++; $display("FAIL midreset_req1 got req=%b addr=%h want 1 200", MemReq, MemAddr); end
    @(negedge Clk); #2; Reset = 0; Req0 = 1; Addr0 = 32'h300;
    @(negedge Clk); Reset = 1;
    @(posedge Clk); #1;
    tests++; if (MemReq !== 1'b1 || MemAddr !== 32'h300) begin fails++; $display("FAIL midreset_tie got req=%b addr=%h want 1 300", MemReq, MemAddr); end
    @(negedge Clk); Req0 = 0; Req1 = 0;
    do_reset();
  endtask

  task automatic test_random();
    int m_act = -1, m_ack = -1, m_wait = 0, m_last = 1, g, acks = 0;
    logic m_we = 0, m_err = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0, m_rdata = '0;
    logic rq [2] = '{0, 0};
    logic rw [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    int bad_ack = 0, bad_stall = 0, bad_req = 0, bad_fld = 0, bad_err = 0, bad_rd = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
        if (m_ack == i) begin
          rq[i] = ($urandom % 3 == 0);
          rw[i] = $urandom; ra[i] = $urandom; rd[i] = $urandom;
        end else if (rq[i] && m_act == i && $urandom % 20 == 0) begin
          rq[i] = 0;
        end else if (!rq[i] && m_act != i && $urandom % 3 == 0) begin
          rq[i] = 1; rw[i] = $urandom; ra[i] = $urandom; rd[i] = $urandom;
        end
      end
      Req0 = rq[0]; Wr0 = rw[0]; Addr0 = ra[0]; WData0 = rd[0];
      Req1 = rq[1]; Wr1 = rw[1]; Addr1 = ra[1]; WData1 = rd[1];
      MemReady = (c < 400) ? ($urandom % 4 != 0) : ($urandom % 20 == 0);
      MemRData = $urandom;
      @(posedge Clk);
      if (m_ack >= 0) begin
        m_ack = -1; m_err = 0;
      end else if (m_act >= 0) begin
        if (MemReady) begin m_rdata = m_we ? '0 : MemRData; m_err = 0; m_ack = m_act; m_act = -1; end
        else if (m_wait == TO - 1) begin m_rdata = '0; m_err = 1; m_ack = m_act; m_act = -1; end
        else m_wait++;
      end else if (rq[0] || rq[1]) begin
        g = (rq[0] && rq[1]) ? 1 - m_last : (rq[0] ? 0 : 1);
        m_last = g; m_act = g; m_wait = 0;
        m_we = rw[g]; m_addr = ra[g]; m_wd = rd[g];
      end
      #1;
      if (m_ack >= 0) acks++;
      if ({Ack1, Ack0} !== {m_ack == 1, m_ack == 0}) bad_ack++;
      if ({Stall1, Stall0} !== {rq[1] && m_ack != 1, rq[0] && m_ack != 0}) bad_stall++;
      if (MemReq !== (m_act >= 0)) bad_req++;
      if (m_act >= 0 && (MemWe !== m_we || MemAddr !== m_addr || MemWData !== m_wd)) bad_fld++;
      if (Err !== (m_ack >= 0 && m_err)) bad_err++;
      if (m_ack >= 0 && RData !== m_rdata) bad_rd++;
    end
    tests++; if (bad_ack != 0) begin fails++; $display("FAIL rand_ack got %0d bad cycles want 0", bad_ack); end
    tests++; if (bad_stall != 0) begin fails++; $display("FAIL rand_stall got %0d bad cycles want 0", bad_stall); end
    tests++; if (bad_req != 0) begin fails++; $display("FAIL rand_memreq got %0d bad cycles want 0", bad_req); end
    tests++; if (bad_fld != 0) begin fails++; $display("FAIL rand_fields got %0d bad cycles want 0", bad_fld); end
    tests++; if (bad_err != 0) begin fails++; $display("FAIL rand_err got %0d bad cycles want 0", bad_err); end
    tests++; if (bad_rd != 0) begin fails++; $display("FAIL rand_rdata got %0d bad cycles want 0", bad_rd); end
    tests++; if (acks < 50) begin fails++; $display("FAIL rand_activity got %0d acks want >=50", acks); end
    @(negedge Clk); Req0 = 0; Req1 = 0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_simultaneous();
    test_contention();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
